// File: rtl/mux_pkg.sv
// Shared definitions for the mux_scan block.
//   - Mode encodings for the 'mode' input port.
//   - FSM state type used by the top level.
package mux_pkg;

    // Values of the 'mode' input.
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Operating state of the multiplexer.
    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

endpackage : mux_pkg

// File: rtl/scan_counter.sv
// Round-robin scan counter for mux_scan.
// Holds the dwell counter (dc) and the scan channel (ch) and produces a
// one-cycle wrap pulse registered on the same edge as the last output of
// channel CHANNELS-1, so it lines up with that output downstream.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset (ch=0, dc=0, wrap=0)
//   load       in   restart sweep at channel 0 with a fresh dwell count
//   advance_en in   count one scan cycle (dwell step / channel advance)
//   ch_o       out  current scan channel
//   wrap_o     out  pulse: channel CHANNELS-1 finished its dwell
module scan_counter
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DWELL    = 1,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance_en,
    output logic [SEL_W-1:0] ch_o,
    output logic             wrap_o
);

    // Dwell counter only needs to reach DWELL-1; keep at least one bit.
    localparam int DC_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DC_W-1:0]  DC_MAX = DC_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_MAX = SEL_W'(CHANNELS - 1);

    logic [DC_W-1:0]  dc_q,   dc_d;
    logic [SEL_W-1:0] ch_q,   ch_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        dc_d   = dc_q;
        ch_d   = ch_q;
        wrap_d = 1'b0;
        if (load) begin
            dc_d = '0;
            ch_d = '0;
        end else if (advance_en) begin
            if (dc_q == DC_MAX) begin
                dc_d = '0;
                if (ch_q == CH_MAX) begin
                    ch_d   = '0;
                    wrap_d = 1'b1;
                end else begin
                    ch_d = ch_q + SEL_W'(1);
                end
            end else begin
                dc_d = dc_q + DC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_q   <= '0;
            ch_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            dc_q   <= dc_d;
            ch_q   <= ch_d;
            wrap_q <= wrap_d;
        end
    end

    assign ch_o   = ch_q;
    assign wrap_o = wrap_q;

endmodule : scan_counter

// File: rtl/mux_scan.sv
// Registered N-channel, W-bit multiplexer with enable and two modes:
// manual select from sel_in, or a round-robin scan that dwells DWELL
// enabled cycles on each channel. All outputs are registered (latency 1).
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   en       in   enable; low holds y/sel_out and freezes the scan
//   mode     in   0 = manual select, 1 = scan
//   sel_in   in   manual channel select
//   x        in   packed channels, channel k = x[k*WIDTH +: WIDTH]
//   y        out  selected data
//   y_valid  out  y was updated this cycle from a legal channel
//   sel_out  out  channel index that produced y
//   wrap     out  one-cycle pulse on the last output of channel CHANNELS-1
module mux_scan
    import mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DWELL    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS*WIDTH-1:0] x,
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      wrap
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   y_q,     y_d;
    logic               vld_q,   vld_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;

    logic               cnt_load;
    logic               cnt_adv;
    logic [SEL_W-1:0]   scan_ch;
    logic               scan_wrap;

    logic [WIDTH-1:0]   man_data;
    logic               man_legal;
    logic [SEL_W-1:0]   man_sel;
    logic [WIDTH-1:0]   scan_data;

    scan_counter #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL),
        .SEL_W    (SEL_W)
    ) u_scan_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .advance_en (cnt_adv),
        .ch_o       (scan_ch),
        .wrap_o     (scan_wrap)
    );

    // Channel selection by equality match rather than indexing, so a select
    // beyond CHANNELS-1 (non-power-of-2 builds) reads as zero and is flagged
    // illegal instead of slicing past the end of x.
    assign man_sel = sel_in;

    always_comb begin
        man_data  = '0;
        man_legal = 1'b0;
        scan_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (man_sel == SEL_W'(k)) begin
                man_data  = x[k*WIDTH +: WIDTH];
                man_legal = 1'b1;
            end
            if (scan_ch == SEL_W'(k)) begin
                scan_data = x[k*WIDTH +: WIDTH];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: mode is honoured whether or not en is high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MANUAL:  if (mode == MODE_SCAN)   state_d = SCAN;
            SCAN:    if (mode == MODE_MANUAL) state_d = MANUAL;
            default: state_d = MANUAL;
        endcase
    end

    // FSM outputs: next values of the output register and counter controls.
    // On the MANUAL->SCAN edge the counter is reloaded and the outputs hold
    // with y_valid low; channel 0 appears on the following edge.
    // On the SCAN->MANUAL edge the manual select already applies.
    always_comb begin
        y_d      = y_q;
        sel_d    = sel_q;
        vld_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_adv  = 1'b0;
        case (state_q)
            MANUAL: begin
                if (mode == MODE_SCAN) begin
                    cnt_load = 1'b1;
                end else if (en) begin
                    y_d   = man_legal ? man_data : '0;
                    sel_d = sel_in;
                    vld_d = man_legal;
                end
            end
            SCAN: begin
                if (mode == MODE_MANUAL) begin
                    if (en) begin
                        y_d   = man_legal ? man_data : '0;
                        sel_d = sel_in;
                        vld_d = man_legal;
                    end
                end else if (en) begin
                    y_d     = scan_data;
                    sel_d   = scan_ch;
                    vld_d   = 1'b1;
                    cnt_adv = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            vld_q <= 1'b0;
            sel_q <= '0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
            sel_q <= sel_d;
        end
    end

    assign y       = y_q;
    assign y_valid = vld_q;
    assign sel_out = sel_q;
    assign wrap    = scan_wrap;

endmodule : mux_scan

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan. Three builds share one clock:
//   dut_a: CHANNELS=4, DWELL=1
//   dut_b: CHANNELS=4, DWELL=3
//   dut_c: CHANNELS=3, DWELL=1
module tb_mux_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- dut_a ----------------
    logic        rst_a, en_a, mode_a;
    logic [1:0]  sel_a;
    logic [15:0] x_a;
    logic [3:0]  y_a;
    logic        vld_a, wrap_a;
    logic [1:0]  so_a;

    mux_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .sel_in(sel_a), .x(x_a),
        .y(y_a), .y_valid(vld_a), .sel_out(so_a), .wrap(wrap_a)
    );

    // ---------------- dut_b ----------------
    logic        rst_b, en_b, mode_b;
    logic [1:0]  sel_b;
    logic [15:0] x_b;
    logic [3:0]  y_b;
    logic        vld_b, wrap_b;
    logic [1:0]  so_b;

    mux_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .sel_in(sel_b), .x(x_b),
        .y(y_b), .y_valid(vld_b), .sel_out(so_b), .wrap(wrap_b)
    );

    // ---------------- dut_c ----------------
    logic        rst_c, en_c, mode_c;
    logic [1:0]  sel_c;
    logic [11:0] x_c;
    logic [3:0]  y_c;
    logic        vld_c, wrap_c;
    logic [1:0]  so_c;

    mux_scan #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut_c (
        .clk(clk), .rst(rst_c), .en(en_c), .mode(mode_c), .sel_in(sel_c), .x(x_c),
        .y(y_c), .y_valid(vld_c), .sel_out(so_c), .wrap(wrap_c)
    );

    // Expected outputs packed as {y[3:0], y_valid, sel_out[1:0], wrap}.
    logic [7:0] exp_v;
    logic [7:0] obs_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b0; mode_a = 1'b0; sel_a = 2'd0; x_a = 16'h8421;
        rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; sel_b = 2'd0; x_b = 16'h8421;
        rst_c = 1'b1; en_c = 1'b0; mode_c = 1'b0; sel_c = 2'd0; x_c = 12'hC93;
        tick();
        exp_v = 8'h00;
        obs_v = {y_a, vld_a, so_a, wrap_a};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL reset_a got=%h want=%h", obs_v, exp_v);
        end
        obs_v = {y_b, vld_b, so_b, wrap_b};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL reset_b got=%h want=%h", obs_v, exp_v);
        end
        obs_v = {y_c, vld_c, so_c, wrap_c};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL reset_c got=%h want=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_manual();
        logic [3:0] ylut [4];
        ylut[0] = 4'd1; ylut[1] = 4'd2; ylut[2] = 4'd4; ylut[3] = 4'd8;
        rst_a = 1'b0; en_a = 1'b1; mode_a = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel_a = 2'(s);
            for (int r = 0; r < 2; r++) begin
                tick();
                exp_v = {ylut[s], 1'b1, 2'(s), 1'b0};
                obs_v = {y_a, vld_a, so_a, wrap_a};
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL manual sel=%0d rep=%0d got=%h want=%h", s, r, obs_v, exp_v);
                end
            end
        end
        // en low in manual: data and tag hold, valid drops.
        en_a = 1'b0; sel_a = 2'd0;
        tick();
        exp_v = {4'd8, 1'b0, 2'd3, 1'b0};
        obs_v = {y_a, vld_a, so_a, wrap_a};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL manual_en_low got=%h want=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_scan_dwell1();
        en_a = 1'b1; mode_a = 1'b1;
        tick();
        // Entry edge: counter reloads, outputs hold with valid low.
        exp_v = {4'd8, 1'b0, 2'd3, 1'b0};
        obs_v = {y_a, vld_a, so_a, wrap_a};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL scan1_entry got=%h want=%h", obs_v, exp_v);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_v = {4'(1 << (i % 4)), 1'b1, 2'(i % 4), ((i % 4) == 3)};
            obs_v = {y_a, vld_a, so_a, wrap_a};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL scan1 cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_scan_dwell3_and_enable();
        int nwrap;
        int ch;
        nwrap = 0;
        rst_b = 1'b1; tick();
        rst_b = 1'b0; en_b = 1'b1; mode_b = 1'b1;
        tick();
        exp_v = 8'h00;
        obs_v = {y_b, vld_b, so_b, wrap_b};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL scan3_entry got=%h want=%h", obs_v, exp_v);
        end
        // 24 cycles of sweep, then channels 0,1 again and the first cycle of 2.
        for (int i = 0; i < 31; i++) begin
            tick();
            ch = (i / 3) % 4;
            exp_v = {4'(1 << ch), 1'b1, 2'(ch), (ch == 3 && (i % 3) == 2)};
            obs_v = {y_b, vld_b, so_b, wrap_b};
            if (i < 24 && wrap_b === 1'b1) nwrap++;
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL scan3 cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
        checks++;
        if (nwrap !== 2) begin
            errors++;
            $display("FAIL scan3_wrap_count got=%0d want=2", nwrap);
        end
        // Freeze on channel 2 (one dwell cycle used).
        en_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_v = {4'd4, 1'b0, 2'd2, 1'b0};
            obs_v = {y_b, vld_b, so_b, wrap_b};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL en_hold cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
        // Resume: two remaining cycles of channel 2, then channel 3 x3.
        en_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_v = (i < 2) ? {4'd4, 1'b1, 2'd2, 1'b0}
                            : {4'd8, 1'b1, 2'd3, (i == 4)};
            obs_v = {y_b, vld_b, so_b, wrap_b};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL en_resume cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        // dut_a is still scanning; reset wins over en=1, mode=1.
        rst_a = 1'b1; en_a = 1'b1; mode_a = 1'b1;
        tick();
        exp_v = 8'h00;
        obs_v = {y_a, vld_a, so_a, wrap_a};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL rst_mid got=%h want=%h", obs_v, exp_v);
        end
        rst_a = 1'b0;
        tick();
        // Back in MANUAL: this edge is the scan entry, so no valid output.
        obs_v = {y_a, vld_a, so_a, wrap_a};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL rst_reentry got=%h want=%h", obs_v, exp_v);
        end
        tick();
        exp_v = {4'd1, 1'b1, 2'd0, 1'b0};
        obs_v = {y_a, vld_a, so_a, wrap_a};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL rst_restart0 got=%h want=%h", obs_v, exp_v);
        end
        tick();
        exp_v = {4'd2, 1'b1, 2'd1, 1'b0};
        obs_v = {y_a, vld_a, so_a, wrap_a};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL rst_restart1 got=%h want=%h", obs_v, exp_v);
        end
        // Scan -> manual: manual select applies on the same edge, no wrap.
        mode_a = 1'b0; sel_a = 2'd3;
        tick();
        exp_v = {4'd8, 1'b1, 2'd3, 1'b0};
        obs_v = {y_a, vld_a, so_a, wrap_a};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL scan_to_manual got=%h want=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_channels3();
        // x_c: ch0=3, ch1=9, ch2=C
        rst_c = 1'b0; en_c = 1'b1; mode_c = 1'b0; sel_c = 2'd3;
        tick();
        exp_v = {4'd0, 1'b0, 2'd3, 1'b0};
        obs_v = {y_c, vld_c, so_c, wrap_c};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL ch3_illegal got=%h want=%h", obs_v, exp_v);
        end
        sel_c = 2'd2;
        tick();
        exp_v = {4'hC, 1'b1, 2'd2, 1'b0};
        obs_v = {y_c, vld_c, so_c, wrap_c};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL ch3_legal got=%h want=%h", obs_v, exp_v);
        end
        // Scan on 3 channels: wrap after channel 2.
        mode_c = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] yl [3];
            yl[0] = 4'h3; yl[1] = 4'h9; yl[2] = 4'hC;
            tick();
            exp_v = {yl[i % 3], 1'b1, 2'(i % 3), ((i % 3) == 2)};
            obs_v = {y_c, vld_c, so_c, wrap_c};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL ch3_scan cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan_dwell1();
        test_scan_dwell3_and_enable();
        test_reset_mid_scan();
        test_channels3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_scan
